// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared types and defaults for the writeback arbiter
package writeback_arbiter_pkg;

  localparam int ADDR_SIZE_DEF = 5;
  localparam int WORD_SIZE_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - requester and register-file write port bundle
interface writeback_arbiter_if
  import writeback_arbiter_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF
) ();

  logic                 pipe_valid_i;
  logic [ADDR_SIZE-1:0] pipe_addr_i;
  logic [WORD_SIZE-1:0] pipe_data_i;
  logic                 pipe_stall_o;
  logic                 mdu_valid_i;
  logic [ADDR_SIZE-1:0] mdu_addr_i;
  logic [WORD_SIZE-1:0] mdu_data_i;
  logic                 mdu_ready_o;
  logic                 rf_we_o;
  logic [ADDR_SIZE-1:0] rf_addr_o;
  logic [WORD_SIZE-1:0] rf_data_o;

  // master: the requesters and register file around the arbiter
  modport master (
    output pipe_valid_i, pipe_addr_i, pipe_data_i,
    output mdu_valid_i, mdu_addr_i, mdu_data_i,
    input  pipe_stall_o, mdu_ready_o,
    input  rf_we_o, rf_addr_o, rf_data_o
  );

  modport slave (
    input  pipe_valid_i, pipe_addr_i, pipe_data_i,
    input  mdu_valid_i, mdu_addr_i, mdu_data_i,
    output pipe_stall_o, mdu_ready_o,
    output rf_we_o, rf_addr_o, rf_data_o
  );

endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - shares the register-file write port between writeback and the MDU
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int MAX_WAIT  = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  writeback_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  arb_state_e           state, state_nx;
  logic [CW-1:0]        wait_cnt, wait_cnt_nx;
  logic                 mdu_ready;
  logic                 pipe_win, mdu_win;
  logic [ADDR_SIZE-1:0] win_addr;
  logic [WORD_SIZE-1:0] win_data;

  assign mdu_ready        = !rst_i && ((state == ST_FORCE) || !bus.pipe_valid_i);
  assign bus.mdu_ready_o  = mdu_ready;
  assign bus.pipe_stall_o = !rst_i && (state == ST_FORCE);

  always_comb begin
    pipe_win = (state != ST_FORCE) && bus.pipe_valid_i;
    mdu_win  = !pipe_win && bus.mdu_valid_i && mdu_ready;
    win_addr = pipe_win ? bus.pipe_addr_i : bus.mdu_addr_i;
    win_data = pipe_win ? bus.pipe_data_i : bus.mdu_data_i;
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    case (state)
      ST_IDLE: begin
        wait_cnt_nx = '0;
        if (bus.mdu_valid_i && !mdu_ready) begin
          // MAX_WAIT of 1 means the very first blocked cycle already exhausts the budget
          state_nx    = (MAX_WAIT == 1) ? ST_FORCE : ST_WAIT;
          wait_cnt_nx = CW'(1);
        end
      end
      ST_WAIT: begin
        if (!bus.mdu_valid_i || mdu_ready) begin
          state_nx    = ST_IDLE;
          wait_cnt_nx = '0;
        end else if (wait_cnt >= CW'(MAX_WAIT - 1)) begin
          state_nx    = ST_FORCE;
          wait_cnt_nx = CW'(MAX_WAIT);
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end
      ST_FORCE: begin
        state_nx    = ST_IDLE;
        wait_cnt_nx = '0;
      end
      default: begin
        state_nx    = ST_IDLE;
        wait_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  // r0 writes are consumed (handshake completes) but never reach the register file
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.rf_we_o   <= 1'b0;
      bus.rf_addr_o <= '0;
      bus.rf_data_o <= '0;
    end else if ((pipe_win || mdu_win) && (win_addr != '0)) begin
      bus.rf_we_o   <= 1'b1;
      bus.rf_addr_o <= win_addr;
      bus.rf_data_o <= win_data;
    end else begin
      bus.rf_we_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed and randomized checks of writeback_arbiter against a priority/age model
module tb_writeback_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_arbiter_if #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) bus ();

  writeback_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .MAX_WAIT(MW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int passes = 0;

  // model: age of the current MDU result in blocked cycles; forced when age hits MW
  int          age = 0;
  logic        m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                      input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                      output logic acc, output logic stalled);
    logic e_stall, e_ready;
    rst = r;
    bus.pipe_valid_i = pv; bus.pipe_addr_i = pa; bus.pipe_data_i = pd;
    bus.mdu_valid_i  = mv; bus.mdu_addr_i  = ma; bus.mdu_data_i  = md;
    #1;
    e_stall = !r && (age == MW);
    e_ready = !r && (e_stall || !pv);
    chk("pipe_stall", {31'd0, bus.pipe_stall_o}, {31'd0, e_stall});
    chk("mdu_ready",  {31'd0, bus.mdu_ready_o},  {31'd0, e_ready});
    if (r) begin
      m_we = 1'b0; m_addr = '0; m_data = '0;
    end else if (!e_stall && pv) begin
      m_we = (pa != 0);
      if (pa != 0) begin m_addr = pa; m_data = pd; end
    end else if (mv && e_ready) begin
      m_we = (ma != 0);
      if (ma != 0) begin m_addr = ma; m_data = md; end
    end else begin
      m_we = 1'b0;
    end
    if (r || e_stall || !mv || e_ready) age = 0;
    else age = (age + 1 > MW) ? MW : age + 1;
    acc     = mv && e_ready;
    stalled = e_stall;
    @(posedge clk);
    #1;
    chk("rf_we",   {31'd0, bus.rf_we_o}, {31'd0, m_we});
    chk("rf_addr", {27'd0, bus.rf_addr_o}, {27'd0, m_addr});
    chk("rf_data", bus.rf_data_o, m_data);
  endtask

  logic acc, stl;
  int   acc_at;
  logic          p_v, m_v;
  logic [AW-1:0] p_a, m_a;
  logic [DW-1:0] p_d, m_d;

  initial begin
    // reset held with both requesters active
    for (int i = 0; i < 3; i++) step(1, 1, 5'd3, 32'h1111_1111, 1, 5'd4, 32'h2222_2222, acc, stl);

    // pipeline alone
    step(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, acc, stl);
    chk("t2_addr", {27'd0, bus.rf_addr_o}, 32'd5);

    // MDU alone: accepted in its first cycle
    step(0, 0, 5'd0, 32'h0, 1, 5'd7, 32'h1234_5678, acc, stl);
    chk("t3_acc", {31'd0, acc}, 32'd1);
    chk("t3_addr", {27'd0, bus.rf_addr_o}, 32'd7);

    // pipeline held busy: MDU forced through after MW blocked cycles
    acc_at = -1;
    for (int i = 0; i < 6 && acc_at < 0; i++) begin
      step(0, 1, AW'(10 + i), $urandom, 1, 5'd9, 32'hCAFE_0009, acc, stl);
      if (acc) acc_at = i;
    end
    chk("t4_force_cycle", acc_at, MW);
    chk("t4_mdu_addr", {27'd0, bus.rf_addr_o}, 32'd9);
    step(0, 1, 5'd12, 32'hABCD_0000, 0, 5'd0, 32'h0, acc, stl);

    // register 0 from either requester
    step(0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 32'h0, acc, stl);
    step(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h5555_5555, acc, stl);
    chk("t5_r0_acc", {31'd0, acc}, 32'd1);

    // reset during WAIT, then the MDU re-presents
    step(0, 1, 5'd1, 32'h0101_0101, 1, 5'd20, 32'h2020_2020, acc, stl);
    step(0, 1, 5'd2, 32'h0202_0202, 1, 5'd20, 32'h2020_2020, acc, stl);
    step(1, 1, 5'd3, 32'h0303_0303, 1, 5'd20, 32'h2020_2020, acc, stl);
    chk("t6_rst_acc", {31'd0, acc}, 32'd0);
    step(0, 0, 5'd0, 32'h0, 1, 5'd20, 32'h2020_2020, acc, stl);
    chk("t6_reaccept", {31'd0, acc}, 32'd1);

    // randomized traffic obeying both hold protocols
    m_v = 1'b0; m_a = '0; m_d = '0;
    p_v = 1'b0; p_a = '0; p_d = '0;
    stl = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic r;
      r = ($urandom_range(0, 63) == 0);
      if (!m_v && $urandom_range(0, 2) == 0) begin
        m_v = 1'b1; m_a = AW'($urandom_range(0, 31)); m_d = $urandom;
      end
      if (!stl) begin
        p_v = ($urandom_range(0, 9) < 7);
        p_a = AW'($urandom_range(0, 31)); p_d = $urandom;
      end
      step(r, p_v, p_a, p_d, m_v, m_a, m_d, acc, stl);
      if (acc) m_v = 1'b0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
